vga_timing_gen: RTL and testbench

//   Free-running VGA raster timing generator for the pattern stages. Produces
//   h_sync/v_sync, pixel coordinates and a display-enable flag, all registered
//   and mutually aligned. Sits directly upstream of the colour/pattern logic,

---
 rtl/vga_timing_gen.sv | 105 ++++++++++
 tb/tb_vga_timing_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing generator.
// Counts, sync and enable flags are all registered and mutually aligned.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 96,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 312,
  parameter int V_ACTIVE = 960,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 36,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1
) (
  input  logic        clk_in,
  input  logic        reset,
  output logic [11:0] h_count,
  output logic [11:0] v_count,
  output logic        display_en,
  output logic        h_sync,
  output logic        v_sync,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 13-bit bounds so a sum reaching 4096 is never truncated.
  localparam logic [12:0] H_ACT_E = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYN_S = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYN_E = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_E = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYN_S = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SYN_E = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);

  logic [11:0] r_h;
  logic [11:0] r_v;
  logic        r_de;
  logic        r_hs;
  logic        r_vs;
  logic        r_ls;
  logic        r_fs;

  logic [11:0] w_h_nxt;
  logic [11:0] w_v_nxt;
  logic        w_h_wrap;
  logic [12:0] w_h_ext;
  logic [12:0] w_v_ext;
  logic        w_de;
  logic        w_hs;
  logic        w_vs;
  logic        w_ls;
  logic        w_fs;

  // Next counts, and flags decoded from them so they align with the counts.
  always_comb begin
    w_h_wrap = (r_h == H_LAST);
    w_h_nxt  = w_h_wrap ? 12'd0 : r_h + 12'd1;
    w_v_nxt  = r_v;
    if (w_h_wrap) begin
      w_v_nxt = (r_v == V_LAST) ? 12'd0 : r_v + 12'd1;
    end
    w_h_ext = {1'b0, w_h_nxt};
    w_v_ext = {1'b0, w_v_nxt};
    w_de = (w_h_ext < H_ACT_E) && (w_v_ext < V_ACT_E);
    w_hs = ((w_h_ext >= H_SYN_S) && (w_h_ext < H_SYN_E)) ? H_POL : ~H_POL;
    w_vs = ((w_v_ext >= V_SYN_S) && (w_v_ext < V_SYN_E)) ? V_POL : ~V_POL;
    w_ls = (w_h_nxt == 12'd0);
    w_fs = w_ls && (w_v_nxt == 12'd0);
  end

  // Reset parks on the last back-porch pixel so the next edge shows (0,0).
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_h  <= H_LAST;
      r_v  <= V_LAST;
      r_de <= 1'b0;
      r_hs <= ~H_POL;
      r_vs <= ~V_POL;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end else begin
      r_h  <= w_h_nxt;
      r_v  <= w_v_nxt;
      r_de <= w_de;
      r_hs <= w_hs;
      r_vs <= w_vs;
      r_ls <= w_ls;
      r_fs <= w_fs;
    end
  end

  assign h_count     = r_h;
  assign v_count     = r_v;
  assign display_en  = r_de;
  assign h_sync      = r_hs;
  assign v_sync      = r_vs;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for the VGA timing generator.
// Small-raster and default-raster instances against an arithmetic model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        de;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } out_t;

  typedef struct {
    int   n;
    out_t e;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [11:0] a_h, a_v, b_h, b_v, d_h, d_v;
  logic a_de, a_hs, a_vs, a_ls, a_fs;
  logic b_de, b_hs, b_vs, b_ls, b_fs;
  logic d_de, d_hs, d_vs, d_ls, d_fs;

  int n = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_a (
    .clk_in(clk), .reset(reset),
    .h_count(a_h), .v_count(a_v), .display_en(a_de),
    .h_sync(a_hs), .v_sync(a_vs),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut_b (
    .clk_in(clk), .reset(reset),
    .h_count(b_h), .v_count(b_v), .display_en(b_de),
    .h_sync(b_hs), .v_sync(b_vs),
    .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen dut_d (
    .clk_in(clk), .reset(reset),
    .h_count(d_h), .v_count(d_v), .display_en(d_de),
    .h_sync(d_hs), .v_sync(d_vs),
    .line_start(d_ls), .frame_start(d_fs)
  );

  // n = edges since release; n==0 means the generator is still in reset.
  function automatic out_t model(int nn, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb,
                                 bit hp, bit vp);
    out_t o;
    int ht, vt, t, h, v;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (nn == 0) begin
      o.h  = 12'(ht - 1);
      o.v  = 12'(vt - 1);
      o.de = 1'b0;
      o.hs = ~hp;
      o.vs = ~vp;
      o.ls = 1'b0;
      o.fs = 1'b0;
    end else begin
      t = nn - 1;
      h = t % ht;
      v = (t / ht) % vt;
      o.h  = 12'(h);
      o.v  = 12'(v);
      o.de = (h < ha) && (v < va);
      o.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
      o.vs = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
      o.ls = (h == 0);
      o.fs = (h == 0) && (v == 0);
    end
    return o;
  endfunction

  function automatic out_t got_a();
    return '{h:a_h, v:a_v, de:a_de, hs:a_hs, vs:a_vs, ls:a_ls, fs:a_fs};
  endfunction
  function automatic out_t got_b();
    return '{h:b_h, v:b_v, de:b_de, hs:b_hs, vs:b_vs, ls:b_ls, fs:b_fs};
  endfunction
  function automatic out_t got_d();
    return '{h:d_h, v:d_v, de:d_de, hs:d_hs, vs:d_vs, ls:d_ls, fs:d_fs};
  endfunction

  task automatic chk(string nm, out_t g, out_t e);
    n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s n=%0d got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b exp h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
        nm, n, g.h, g.v, g.de, g.hs, g.vs, g.ls, g.fs,
        e.h, e.v, e.de, e.hs, e.vs, e.ls, e.fs);
    end
  endtask

  task automatic chk_int(string nm, int g, int e);
    n_checks++;
    if (g != e) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", nm, g, e);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "/a"}, got_a(), model(n, 16, 2, 3, 4, 6, 1, 2, 2, 1'b1, 1'b1));
    chk({tag, "/b"}, got_b(), model(n, 16, 2, 3, 4, 6, 1, 2, 2, 1'b0, 1'b0));
    chk({tag, "/d"}, got_d(),
        model(n, 1280, 96, 112, 312, 960, 1, 3, 36, 1'b1, 1'b1));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    if (!reset) n++;
    #1;
    check_all(tag);
  endtask

  // Called just after a sampled edge; asserts reset well before the next one.
  task automatic async_reset(string tag);
    #2;
    reset = 1'b1;
    n = 0;
    #1;
    check_all(tag);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vecs[14];
  int de_cnt, hs_cnt, hs_first, ls_cnt, ls_first, ls_last, fs_cnt, vs_cnt;

  initial begin
    vecs[0]  = '{n:1,   e:'{h:0,  v:0,  de:1, hs:0, vs:0, ls:1, fs:1}};
    vecs[1]  = '{n:16,  e:'{h:15, v:0,  de:1, hs:0, vs:0, ls:0, fs:0}};
    vecs[2]  = '{n:17,  e:'{h:16, v:0,  de:0, hs:0, vs:0, ls:0, fs:0}};
    vecs[3]  = '{n:19,  e:'{h:18, v:0,  de:0, hs:1, vs:0, ls:0, fs:0}};
    vecs[4]  = '{n:21,  e:'{h:20, v:0,  de:0, hs:1, vs:0, ls:0, fs:0}};
    vecs[5]  = '{n:22,  e:'{h:21, v:0,  de:0, hs:0, vs:0, ls:0, fs:0}};
    vecs[6]  = '{n:25,  e:'{h:24, v:0,  de:0, hs:0, vs:0, ls:0, fs:0}};
    vecs[7]  = '{n:26,  e:'{h:0,  v:1,  de:1, hs:0, vs:0, ls:1, fs:0}};
    vecs[8]  = '{n:151, e:'{h:0,  v:6,  de:0, hs:0, vs:0, ls:1, fs:0}};
    vecs[9]  = '{n:176, e:'{h:0,  v:7,  de:0, hs:0, vs:1, ls:1, fs:0}};
    vecs[10] = '{n:225, e:'{h:24, v:8,  de:0, hs:0, vs:1, ls:0, fs:0}};
    vecs[11] = '{n:226, e:'{h:0,  v:9,  de:0, hs:0, vs:0, ls:1, fs:0}};
    vecs[12] = '{n:275, e:'{h:24, v:10, de:0, hs:0, vs:0, ls:0, fs:0}};
    vecs[13] = '{n:276, e:'{h:0,  v:0,  de:1, hs:0, vs:0, ls:1, fs:1}};

    // Reset held for five edges, then released.
    #1;
    reset = 1'b1;
    repeat (5) tick("rst_hold");
    release_reset();

    // Table of hand-computed points across one small frame and its wrap.
    foreach (vecs[i]) begin
      while (n < vecs[i].n) tick("tbl_run");
      chk($sformatf("tbl%0d", i), got_a(), vecs[i].e);
    end

    // One more small frame: a single frame_start, v_sync for 2 lines.
    fs_cnt = 0;
    vs_cnt = 0;
    repeat (275) begin
      tick("frame");
      if (a_fs) fs_cnt++;
      if (a_vs) vs_cnt++;
    end
    chk_int("small_fs_per_frame", fs_cnt, 1);
    chk_int("small_vs_cycles", vs_cnt, 50);

    // Random run lengths with random asynchronous resets.
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(1, 600)) tick("rand");
      if ($urandom_range(0, 1) == 1) begin
        async_reset("rand_arst");
        repeat ($urandom_range(0, 3)) tick("rand_hold");
        release_reset();
      end
    end

    // Default raster: one full line of measurements.
    @(posedge clk);
    #1;
    async_reset("d_arst0");
    tick("d_hold");
    release_reset();
    de_cnt = 0;
    hs_cnt = 0;
    hs_first = -1;
    ls_cnt = 0;
    ls_first = -1;
    ls_last = -1;
    repeat (1801) begin
      tick("d_line");
      if (n <= 1800 && d_de) de_cnt++;
      if (n <= 1800 && d_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(d_h);
      end
      if (d_ls) begin
        ls_cnt++;
        if (ls_first < 0) ls_first = n;
        ls_last = n;
      end
    end
    chk_int("d_de_cycles", de_cnt, 1280);
    chk_int("d_hs_cycles", hs_cnt, 112);
    chk_int("d_hs_first_h", hs_first, 1376);
    chk_int("d_ls_count", ls_cnt, 2);
    chk_int("d_ls_period", ls_last - ls_first, 1800);

    // Mid-line asynchronous reset at h=700, then restart at (0,0).
    while (n < 2501) tick("d_to700");
    chk_int("d_h_before_arst", int'(d_h), 700);
    async_reset("d_arst_mid");
    chk_int("d_h_in_arst", int'(d_h), 1799);
    chk_int("d_v_in_arst", int'(d_v), 999);
    release_reset();
    tick("d_restart");
    chk_int("d_restart_fs", int'(d_fs), 1);
    chk_int("d_restart_h", int'(d_h), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
